// File: rtl/vga_pkg.sv
// 640x480@60 Hz VGA timing constants and counter types shared by the scanner slice.
package vga_pkg;

  typedef logic [9:0] h_cnt_t;
  typedef logic [9:0] v_cnt_t;

  localparam h_cnt_t H_ACTIVE = 10'd640;
  localparam h_cnt_t H_FP     = 10'd16;
  localparam h_cnt_t H_SYNC   = 10'd96;
  localparam h_cnt_t H_BP     = 10'd48;
  localparam h_cnt_t H_TOTAL  = 10'd800;

  localparam v_cnt_t V_ACTIVE = 10'd480;
  localparam v_cnt_t V_FP     = 10'd10;
  localparam v_cnt_t V_SYNC   = 10'd2;
  localparam v_cnt_t V_BP     = 10'd33;
  localparam v_cnt_t V_TOTAL  = 10'd525;

  localparam h_cnt_t H_LAST       = H_TOTAL - 10'd1;
  localparam v_cnt_t V_LAST       = V_TOTAL - 10'd1;
  localparam h_cnt_t H_SYNC_START = H_ACTIVE + H_FP;
  localparam h_cnt_t H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam v_cnt_t V_SYNC_START = V_ACTIVE + V_FP;
  localparam v_cnt_t V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA h/v counters with raw (unaligned) sync and active flags.
module vga_timing
  import vga_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   pix_en,
  output h_cnt_t h_cnt,
  output v_cnt_t v_cnt,
  output logic   hsync_raw,
  output logic   vsync_raw,
  output logic   active,
  output logic   line_end,
  output logic   frame_end
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign hsync_raw = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
  assign vsync_raw = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
  assign active    = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);

endmodule

// File: rtl/vga_image_scanner.sv
// Scans a Width x Height image onto 640x480 VGA with integer replication.
// Optional white cell grid overlay: define VGA_IMAGE_SCANNER_GRID_EN.
module vga_image_scanner
  import vga_pkg::*;
#(
  parameter int Width     = 50,
  parameter int Height    = 50,
  parameter int ColorBits = 3,
  parameter int Scale     = 8,
  parameter logic [ColorBits-1:0] BorderColor = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  output logic [8:0]           XRead,
  output logic [7:0]           YRead,
  input  logic [ColorBits-1:0] ReadValue,
  output logic                 vga_r,
  output logic                 vga_g,
  output logic                 vga_b,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic                 frame_start
);

  localparam logic [9:0] WIDTH_L  = 10'(Width);
  localparam logic [9:0] HEIGHT_L = 10'(Height);
  localparam logic [9:0] SCALE_M1 = 10'(Scale - 1);

  h_cnt_t h_cnt;
  v_cnt_t v_cnt;
  logic   hsync_raw, vsync_raw, active, line_end, frame_end;

  vga_timing u_timing (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .active    (active),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Image walk: sub-counters replace a divide by Scale.
  logic [9:0] sub_x, img_x, sub_y, img_y;
  logic       in_image;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_x <= '0;
      img_x <= '0;
      sub_y <= '0;
      img_y <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        sub_x <= '0;
        img_x <= '0;
      end else if (sub_x == SCALE_M1) begin
        sub_x <= '0;
        img_x <= img_x + 10'd1;
      end else begin
        sub_x <= sub_x + 10'd1;
      end
      if (frame_end) begin
        sub_y <= '0;
        img_y <= '0;
      end else if (line_end) begin
        if (sub_y == SCALE_M1) begin
          sub_y <= '0;
          img_y <= img_y + 10'd1;
        end else begin
          sub_y <= sub_y + 10'd1;
        end
      end
    end
  end

  assign in_image = active && (img_x < WIDTH_L) && (img_y < HEIGHT_L);

  function automatic logic [ColorBits-1:0] pick_color(input logic von, input logic in_img,
                                                      input logic [ColorBits-1:0] mem);
    if (!von)    return '0;
    if (!in_img) return BorderColor;
    return mem;
  endfunction

  // Stage p0: address issue, control flags captured alongside
  logic hs_p0, vs_p0, von_p0, in_p0, first_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      XRead    <= '0;
      YRead    <= '0;
      hs_p0    <= 1'b1;
      vs_p0    <= 1'b1;
      von_p0   <= 1'b0;
      in_p0    <= 1'b0;
      first_p0 <= 1'b0;
    end else if (pix_en) begin
      XRead    <= in_image ? img_x[8:0] : '0;
      YRead    <= in_image ? img_y[7:0] : '0;
      hs_p0    <= hsync_raw;
      vs_p0    <= vsync_raw;
      von_p0   <= active;
      in_p0    <= in_image;
      first_p0 <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  logic [ColorBits-1:0] color_next;

`ifdef VGA_IMAGE_SCANNER_GRID_EN
  logic grid_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) grid_p0 <= 1'b0;
    else if (pix_en) grid_p0 <= (sub_x == '0) || (sub_y == '0);
  end

  assign color_next = (in_p0 && grid_p0) ? '1 : pick_color(von_p0, in_p0, ReadValue);
`else
  assign color_next = pick_color(von_p0, in_p0, ReadValue);
`endif

  // Stage p1: memory data returned, colour and syncs registered to pins
  logic [ColorBits-1:0] rgb_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_p1   <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else if (pix_en) begin
      rgb_p1   <= color_next;
      hsync    <= hs_p0;
      vsync    <= vs_p0;
      video_on <= von_p0;
    end
  end

  // Single-clk pulse even though the pixel it marks is held for a whole tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_start <= 1'b0;
    else     frame_start <= pix_en && first_p0;
  end

  assign vga_r = rgb_p1[2];
  assign vga_g = rgb_p1[1];
  assign vga_b = rgb_p1[0];

endmodule
